mem_port_ctrl: RTL and testbench
================================

// Module: mem_port_ctrl
// PURPOSE
//  Memory-port controller between the multi-cycle CPU and the unified Memory block.
//  DM occupies the low addresses and IM the high addresses.
//  Arbitrates instruction-fetch and load/store requests onto the single Memory port.
//  Derives byte enables and sign control from access size and address, detects faults,
//  and returns registered read data (MDR/IR) with a one-cycle valid pulse.
// PARAMETERS
//  IM_BASE    32'h0000_3000  first byte address of IM; stores at or above it fault
//  LS_FIRST   1              1: load/store wins a simultaneous request; 0: fetch wins
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   asynchronous, active-low reset
//  IfReq_i      in   1   fetch request, held until IfGnt_o
//  IfAddr_i     in   32  fetch byte address; bits [1:0] ignored
//  IfGnt_o      out  1   fetch accepted (1-cycle pulse)
//  IfValid_o    out  1   Instr_o valid (1-cycle pulse)
//  Instr_o      out  32  fetched word, held until next fetch response
//  LsReq_i      in   1   load/store request, held until LsGnt_o
//  LsWrite_i    in   1   1 store, 0 load
//  LsSize_i     in   2   00 byte, 01 half, 10 word, 11 reserved (fault)
//  LsUnsigned_i in   1   load zero-extends (lbu/lhu)
//  LsAddr_i     in   32  load/store byte address
//  LsWData_i    in   32  store data, right-justified
//  LsGnt_o      out  1   load/store accepted (1-cycle pulse)
//  LsValid_o    out  1   load/store complete (1-cycle pulse)
//  LsFault_o    out  1   qualifies LsValid_o: misaligned, reserved size, or store >= IM_BASE
//  LsRData_o    out  32  extended load data, held until next LS response; 0 on fault
//  MemAddr_o    out  32  to Memory Addr_i
//  MemDataIn_o  out  32  to Memory DataIn_i
//  MemWrite_o   out  1   to Memory MemWrite_i
//  MemBE_o      out  4   to Memory BE_i
//  MemSign_o    out  1   to Memory Sign_i
//  MemDataOut_i in   32  from Memory DataOut_o (combinational read)
// BEHAVIOUR
//  FSM states: IDLE, ACCESS, RESP.
//  Request capture:
//   - A request is accepted only in IDLE. Gnt is driven combinationally in IDLE.
//   - Address, size, write flag, unsigned flag, data and source (IF/LS) are latched at that edge.
//   - Simultaneous IfReq_i and LsReq_i: LS_FIRST selects the winner. The loser stays pending.
//  Transitions:
//   - IDLE -> ACCESS when the accepted request has no fault.
//   - IDLE -> RESP when an LS request faults. No Memory access occurs.
//   - ACCESS -> RESP always. In ACCESS, Memory is driven from the latched request.
//   - MemDataOut_i is captured into Instr_o/LsRData_o at the end of ACCESS.
//   - RESP -> IDLE always. Valid pulses in RESP.
//  Latency: request granted at edge N -> valid during cycle N+2; faulted LS -> N+1.
//   Back-to-back throughput is one access per 3 cycles.
//  Byte-enable derivation:
//   - byte: addr[1:0] = 0/1/2/3 -> BE 0001/0010/0100/1000
//   - half: addr[1] = 0/1 -> BE 0011/1100; addr[0] = 1 faults
//   - word: BE 1111; addr[1:0] != 0 faults
//   - fetch: BE 1111, MemSign_o = 0
//  Memory drive:
//   - MemSign_o = ~LsUnsigned. MemDataIn_o = LsWData unshifted (Memory selects the lane).
//   - MemWrite_o = 1 only in ACCESS for a store, decoded from the state register (no glitch).
//  Outside ACCESS: MemBE_o = 0000, MemWrite_o = 0, MemAddr_o = 0, MemDataIn_o = 0.
//  Reset values: state IDLE; all outputs 0, including Instr_o and LsRData_o.
//   Reset asserted mid-ACCESS drops MemWrite_o immediately. The request is lost with no response.
//  Reserved size with LsReq_i: fault response, same as misalignment.
// TESTING
//  1. sw 0x11223344 @0x10, then lw @0x10 -> 1 write at ACCESS; LsRData_o = 0x11223344 at N+2.
//  2. Word 0x0000_80F0 @0x20; lb @0x20 -> BE 0001, 0xFFFFFFF0; lbu @0x21 -> BE 0010, 0x00000080.
//  3. lh @0x22 on word 0x8001_0000 -> BE 1100, 0xFFFF8001; lh @0x23 -> LsFault_o, 0, no mem access.
//  4. Same-cycle IfReq_i @0x3000 and LsReq_i, LS_FIRST=1 -> LS granted first.
//     Fetch granted in the cycle after the LS RESP; Instr_o = Mem[0xC00].
//  5. sw @0x3004 -> LsFault_o at N+1, MemWrite_o never high; IM contents unchanged.
//  6. rst low during ACCESS of a store -> MemWrite_o low at once; after release, IDLE, outputs 0.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - fetch/load-store arbiter driving the single unified Memory port
module mem_port_ctrl #(
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter bit          LS_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IfReq_i,
    input  logic [31:0] IfAddr_i,
    output logic        IfGnt_o,
    output logic        IfValid_o,
    output logic [31:0] Instr_o,
    input  logic        LsReq_i,
    input  logic        LsWrite_i,
    input  logic [1:0]  LsSize_i,
    input  logic        LsUnsigned_i,
    input  logic [31:0] LsAddr_i,
    input  logic [31:0] LsWData_i,
    output logic        LsGnt_o,
    output logic        LsValid_o,
    output logic        LsFault_o,
    output logic [31:0] LsRData_o,
    output logic [31:0] MemAddr_o,
    output logic [31:0] MemDataIn_o,
    output logic        MemWrite_o,
    output logic [3:0]  MemBE_o,
    output logic        MemSign_o,
    input  logic [31:0] MemDataOut_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        src_ls;
    logic        lat_write;
    logic        lat_unsigned;
    logic        lat_fault;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        ls_fault_c;
    logic [3:0]  ls_be;

    always_comb begin
        IfGnt_o = 1'b0;
        LsGnt_o = 1'b0;
        if (state == IDLE) begin
            LsGnt_o = LsReq_i && !(IfReq_i && !LS_FIRST);
            IfGnt_o = IfReq_i && !(LsReq_i && LS_FIRST);
        end
    end

    // Stores into IM are refused; only LS requests can fault.
    always_comb begin
        ls_fault_c = (LsSize_i == 2'b11)
                   || ((LsSize_i == 2'b01) && LsAddr_i[0])
                   || ((LsSize_i == 2'b10) && (LsAddr_i[1:0] != 2'b00))
                   || (LsWrite_i && (LsAddr_i >= IM_BASE));
    end

    always_comb begin
        case (lat_size)
            2'b00:   ls_be = 4'b0001 << lat_addr[1:0];
            2'b01:   ls_be = lat_addr[1] ? 4'b1100 : 4'b0011;
            default: ls_be = 4'b1111;
        endcase
    end

    // Memory is driven only while the state register says ACCESS.
    always_comb begin
        MemAddr_o   = 32'd0;
        MemDataIn_o = 32'd0;
        MemWrite_o  = 1'b0;
        MemBE_o     = 4'b0000;
        MemSign_o   = 1'b0;
        if (state == ACCESS) begin
            if (src_ls) begin
                MemAddr_o   = lat_addr;
                MemDataIn_o = lat_wdata;
                MemWrite_o  = lat_write;
                MemBE_o     = ls_be;
                MemSign_o   = ~lat_unsigned;
            end else begin
                MemAddr_o   = {lat_addr[31:2], 2'b00};
                MemBE_o     = 4'b1111;
            end
        end
    end

    always_comb begin
        IfValid_o = (state == RESP) && !src_ls;
        LsValid_o = (state == RESP) && src_ls;
        LsFault_o = (state == RESP) && src_ls && lat_fault;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            src_ls       <= 1'b0;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_fault    <= 1'b0;
            lat_size     <= 2'b00;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            Instr_o      <= 32'd0;
            LsRData_o    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (LsGnt_o) begin
                        src_ls       <= 1'b1;
                        lat_write    <= LsWrite_i;
                        lat_unsigned <= LsUnsigned_i;
                        lat_fault    <= ls_fault_c;
                        lat_size     <= LsSize_i;
                        lat_addr     <= LsAddr_i;
                        lat_wdata    <= LsWData_i;
                        if (ls_fault_c) begin
                            LsRData_o <= 32'd0;
                            state     <= RESP;
                        end else begin
                            state     <= ACCESS;
                        end
                    end else if (IfGnt_o) begin
                        src_ls       <= 1'b0;
                        lat_write    <= 1'b0;
                        lat_unsigned <= 1'b0;
                        lat_fault    <= 1'b0;
                        lat_size     <= 2'b10;
                        lat_addr     <= IfAddr_i;
                        lat_wdata    <= 32'd0;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (src_ls) begin
                        if (!lat_write) LsRData_o <= MemDataOut_i;
                    end else begin
                        Instr_o <= MemDataOut_i;
                    end
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - directed self-checking bench for mem_port_ctrl with a behavioural Memory
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        IfReq_i = 1'b0;
    logic [31:0] IfAddr_i = 32'd0;
    logic        IfGnt_o, IfValid_o;
    logic [31:0] Instr_o;
    logic        LsReq_i = 1'b0, LsWrite_i = 1'b0, LsUnsigned_i = 1'b0;
    logic [1:0]  LsSize_i = 2'b00;
    logic [31:0] LsAddr_i = 32'd0, LsWData_i = 32'd0;
    logic        LsGnt_o, LsValid_o, LsFault_o;
    logic [31:0] LsRData_o;
    logic [31:0] MemAddr_o, MemDataIn_o, MemDataOut_i;
    logic        MemWrite_o, MemSign_o;
    logic [3:0]  MemBE_o;

    int checks = 0;
    int errors = 0;
    int wcount;
    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    mem_port_ctrl dut (
        .clk(clk), .rst(rst),
        .IfReq_i(IfReq_i), .IfAddr_i(IfAddr_i), .IfGnt_o(IfGnt_o),
        .IfValid_o(IfValid_o), .Instr_o(Instr_o),
        .LsReq_i(LsReq_i), .LsWrite_i(LsWrite_i), .LsSize_i(LsSize_i),
        .LsUnsigned_i(LsUnsigned_i), .LsAddr_i(LsAddr_i), .LsWData_i(LsWData_i),
        .LsGnt_o(LsGnt_o), .LsValid_o(LsValid_o), .LsFault_o(LsFault_o),
        .LsRData_o(LsRData_o),
        .MemAddr_o(MemAddr_o), .MemDataIn_o(MemDataIn_o), .MemWrite_o(MemWrite_o),
        .MemBE_o(MemBE_o), .MemSign_o(MemSign_o), .MemDataOut_i(MemDataOut_i)
    );

    // Memory read: lane chosen by BE, extended by Sign.
    logic [31:0] rd_word;
    always_comb begin
        rd_word = mem[MemAddr_o[13:2]];
        case (MemBE_o)
            4'b0001: MemDataOut_i = {{24{MemSign_o & rd_word[7]}},  rd_word[7:0]};
            4'b0010: MemDataOut_i = {{24{MemSign_o & rd_word[15]}}, rd_word[15:8]};
            4'b0100: MemDataOut_i = {{24{MemSign_o & rd_word[23]}}, rd_word[23:16]};
            4'b1000: MemDataOut_i = {{24{MemSign_o & rd_word[31]}}, rd_word[31:24]};
            4'b0011: MemDataOut_i = {{16{MemSign_o & rd_word[15]}}, rd_word[15:0]};
            4'b1100: MemDataOut_i = {{16{MemSign_o & rd_word[31]}}, rd_word[31:16]};
            default: MemDataOut_i = rd_word;
        endcase
    end

    // Preload during reset; lane writes with right-justified data otherwise.
    always @(posedge clk) begin
        if (!rst) begin
            wcount            <= 0;
            mem[16]           <= 32'd0;
            mem[12'hC00]      <= 32'hDEAD_BEEF;
            mem[12'hC01]      <= 32'hCAFE_F00D;
        end else if (MemWrite_o) begin
            wcount <= wcount + 1;
            case (MemBE_o)
                4'b0001: mem[MemAddr_o[13:2]][7:0]   <= MemDataIn_o[7:0];
                4'b0010: mem[MemAddr_o[13:2]][15:8]  <= MemDataIn_o[7:0];
                4'b0100: mem[MemAddr_o[13:2]][23:16] <= MemDataIn_o[7:0];
                4'b1000: mem[MemAddr_o[13:2]][31:24] <= MemDataIn_o[7:0];
                4'b0011: mem[MemAddr_o[13:2]][15:0]  <= MemDataIn_o[15:0];
                4'b1100: mem[MemAddr_o[13:2]][31:16] <= MemDataIn_o[15:0];
                default: mem[MemAddr_o[13:2]]        <= MemDataIn_o;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one LS request, checks the grant, and returns 1 ns after the accepting edge.
    task automatic ls_issue(input logic w, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        LsReq_i = 1'b1; LsWrite_i = w; LsSize_i = sz; LsUnsigned_i = uns;
        LsAddr_i = a; LsWData_i = d;
        #1;
        n = 0;
        while (!LsGnt_o && n < 8) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ls_gnt", {31'd0, LsGnt_o}, 32'd1);
        @(posedge clk); #1;
        LsReq_i = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        int wc;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ifgnt",  {31'd0, IfGnt_o},    32'd0);
        chk("rst_lsvalid",{31'd0, LsValid_o},  32'd0);
        chk("rst_instr",  Instr_o,             32'd0);
        chk("rst_rdata",  LsRData_o,           32'd0);
        chk("rst_be",     {28'd0, MemBE_o},    32'd0);
        chk("rst_memwr",  {31'd0, MemWrite_o}, 32'd0);
        chk("rst_addr",   MemAddr_o,           32'd0);
        @(negedge clk); rst = 1'b1;

        // 1: sw then lw
        ls_issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
        chk("sw_memwr",  {31'd0, MemWrite_o}, 32'd1);
        chk("sw_be",     {28'd0, MemBE_o},    32'hF);
        chk("sw_addr",   MemAddr_o,           32'h10);
        chk("sw_din",    MemDataIn_o,         32'h1122_3344);
        step;
        chk("sw_valid",  {31'd0, LsValid_o},  32'd1);
        chk("sw_fault",  {31'd0, LsFault_o},  32'd0);
        chk("sw_wr_off", {31'd0, MemWrite_o}, 32'd0);
        step;
        chk("sw_mem",    mem[4],              32'h1122_3344);
        chk("sw_wcount", wcount,              32'd1);
        ls_issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        chk("lw_memwr",  {31'd0, MemWrite_o}, 32'd0);
        chk("lw_valid_early", {31'd0, LsValid_o}, 32'd0);
        step;
        chk("lw_valid",  {31'd0, LsValid_o},  32'd1);
        chk("lw_rdata",  LsRData_o,           32'h1122_3344);

        // 2: lb / lbu on 0x000080F0
        ls_issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_80F0);
        step; step;
        ls_issue(1'b0, 2'b00, 1'b0, 32'h20, 32'd0);
        chk("lb_be",     {28'd0, MemBE_o},    32'b0001);
        chk("lb_sign",   {31'd0, MemSign_o},  32'd1);
        step;
        chk("lb_rdata",  LsRData_o,           32'hFFFF_FFF0);
        ls_issue(1'b0, 2'b00, 1'b1, 32'h21, 32'd0);
        chk("lbu_be",    {28'd0, MemBE_o},    32'b0010);
        chk("lbu_sign",  {31'd0, MemSign_o},  32'd0);
        step;
        chk("lbu_rdata", LsRData_o,           32'h0000_0080);

        // 3: lh aligned and misaligned on 0x80010000
        ls_issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h8001_0000);
        step; step;
        ls_issue(1'b0, 2'b01, 1'b0, 32'h22, 32'd0);
        chk("lh_be",     {28'd0, MemBE_o},    32'b1100);
        step;
        chk("lh_rdata",  LsRData_o,           32'hFFFF_8001);
        ls_issue(1'b0, 2'b01, 1'b0, 32'h23, 32'd0);
        chk("lhm_valid", {31'd0, LsValid_o},  32'd1);
        chk("lhm_fault", {31'd0, LsFault_o},  32'd1);
        chk("lhm_rdata", LsRData_o,           32'd0);
        chk("lhm_be",    {28'd0, MemBE_o},    32'd0);
        step;

        // reserved size faults the same way
        ls_issue(1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
        chk("rsv_fault", {31'd0, LsFault_o},  32'd1);
        step;

        // 4: simultaneous fetch and load, LS wins
        @(negedge clk);
        IfReq_i = 1'b1; IfAddr_i = 32'h3000;
        LsReq_i = 1'b1; LsWrite_i = 1'b0; LsSize_i = 2'b10; LsUnsigned_i = 1'b0;
        LsAddr_i = 32'h10;
        #1;
        chk("arb_lsgnt", {31'd0, LsGnt_o},    32'd1);
        chk("arb_ifgnt", {31'd0, IfGnt_o},    32'd0);
        step;
        LsReq_i = 1'b0;
        chk("arb_addr",  MemAddr_o,           32'h10);
        chk("arb_ifgnt_acc", {31'd0, IfGnt_o}, 32'd0);
        step;
        chk("arb_lsvalid", {31'd0, LsValid_o}, 32'd1);
        chk("arb_ifgnt_resp", {31'd0, IfGnt_o}, 32'd0);
        step;
        chk("if_gnt",    {31'd0, IfGnt_o},    32'd1);
        step;
        IfReq_i = 1'b0;
        chk("if_addr",   MemAddr_o,           32'h3000);
        chk("if_be",     {28'd0, MemBE_o},    32'hF);
        chk("if_sign",   {31'd0, MemSign_o},  32'd0);
        step;
        chk("if_valid",  {31'd0, IfValid_o},  32'd1);
        chk("if_instr",  Instr_o,             32'hDEAD_BEEF);
        step;

        // 5: store into IM faults without touching Memory
        wc = wcount;
        ls_issue(1'b1, 2'b10, 1'b0, 32'h3004, 32'h0000_0055);
        chk("im_fault",  {31'd0, LsFault_o},  32'd1);
        chk("im_valid",  {31'd0, LsValid_o},  32'd1);
        chk("im_memwr",  {31'd0, MemWrite_o}, 32'd0);
        step;
        chk("im_mem",    mem[12'hC01],        32'hCAFE_F00D);
        chk("im_wcount", wcount,              wc);

        // 6: reset during a store ACCESS
        ls_issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5_A5A5);
        chk("rs_memwr_on", {31'd0, MemWrite_o}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rs_memwr_off", {31'd0, MemWrite_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("rs_mem",    mem[16],             32'd0);
        chk("rs_rdata",  LsRData_o,           32'd0);
        chk("rs_instr",  Instr_o,             32'd0);
        step;
        chk("rs_novalid", {31'd0, LsValid_o}, 32'd0);
        chk("rs_be",     {28'd0, MemBE_o},    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
